// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared SPI controller types, transfer lengths and mode decode
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int SPI_MAX_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SCK_LOW  = 3'd2,
    ST_SCK_HIGH = 3'd3,
    ST_CS_HOLD  = 3'd4
  } spi_state_t;

  typedef enum logic [1:0] {
    LEN8  = 2'd0,
    LEN16 = 2'd1,
    LEN24 = 2'd2
  } spi_len_t;

  // Mode 3 is reserved and falls back to a single byte.
  function automatic spi_len_t mode_to_len(input logic [1:0] mode);
    case (mode)
      2'd1:    return LEN16;
      2'd2:    return LEN24;
      default: return LEN8;
    endcase
  endfunction

  function automatic logic [4:0] mode_to_bits(input logic [1:0] mode);
    case (mode_to_len(mode))
      LEN16:   return 5'd16;
      LEN24:   return 5'd24;
      default: return 5'd8;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_controller.sv
// ============================================================================
// spi_byte_controller : SPI mode-0 master, 8/16/24-bit MSB-first transfers
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_byte_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [23:0] i_data,
  input  logic [1:0]  i_mode,
  input  logic        i_dc,
  output logic [23:0] o_rx_data,
  output logic        o_rx_valid,
  output logic        display_csb,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        data_commandb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  spi_state_t        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        idx_q, idx_d;
  logic [23:0]       tx_q, tx_d;
  logic [23:0]       rx_q, rx_d;
  logic              dc_q, dc_d;
  logic              csb_q, csb_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              dcb_q, dcb_d;
  logic [23:0]       rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              w_div_done;

  assign o_ready       = (state_q == ST_IDLE);
  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign display_csb   = csb_q;
  assign spi_clk       = sck_q;
  assign spi_mosi      = mosi_q;
  assign data_commandb = dcb_q;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    idx_d      = idx_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    dc_d       = dc_q;
    csb_d      = csb_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    dcb_d      = dcb_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    w_div_done = (div_q == DIV_LAST);

    if (state_q != ST_IDLE) begin
      div_d = w_div_done ? '0 : div_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          tx_d    = i_data;
          dc_d    = i_dc;
          idx_d   = mode_to_bits(i_mode) - 5'd1;
          rx_d    = '0;
          div_d   = '0;
          state_d = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (w_div_done) state_d = ST_SCK_LOW;
      end
      ST_SCK_LOW: begin
        // This edge is also the SCK rising edge, so MISO is sampled here.
        if (w_div_done) begin
          rx_d    = {rx_q[22:0], spi_miso};
          state_d = ST_SCK_HIGH;
        end
      end
      ST_SCK_HIGH: begin
        if (w_div_done) begin
          if (idx_q == 5'd0) begin
            state_d = ST_CS_HOLD;
          end else begin
            idx_d   = idx_q - 5'd1;
            state_d = ST_SCK_LOW;
          end
        end
      end
      ST_CS_HOLD: begin
        if (w_div_done) begin
          rx_data_d  = rx_q;
          rx_valid_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are registered from the next state so they line up with it.
    case (state_d)
      ST_IDLE: begin
        csb_d = 1'b1;
        sck_d = 1'b0;
      end
      ST_CS_SETUP: begin
        csb_d  = 1'b0;
        sck_d  = 1'b0;
        dcb_d  = dc_d;
        mosi_d = tx_d[idx_d];
      end
      ST_SCK_LOW: begin
        csb_d  = 1'b0;
        sck_d  = 1'b0;
        mosi_d = tx_d[idx_d];
      end
      ST_SCK_HIGH: begin
        csb_d = 1'b0;
        sck_d = 1'b1;
      end
      ST_CS_HOLD: begin
        csb_d = 1'b0;
        sck_d = 1'b0;
      end
      default: begin
        csb_d = 1'b1;
        sck_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      idx_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      dc_q       <= 1'b0;
      csb_q      <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      dcb_q      <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      dc_q       <= dc_d;
      csb_q      <= csb_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      dcb_q      <= dcb_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_controller.sv
// ============================================================================
// tb_spi_byte_controller : directed table-driven bench for spi_byte_controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_byte_controller;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [23:0] i_data;
  logic [1:0]  i_mode;
  logic        i_dc;
  logic [23:0] o_rx_data;
  logic        o_rx_valid;
  logic        display_csb;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        data_commandb;

  // 0: loopback from MOSI, 1: tied high, 2: tied low
  int miso_sel;
  assign spi_miso = (miso_sel == 0) ? spi_mosi : (miso_sel == 1);

  spi_byte_controller #(.CLK_DIV(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_data        (i_data),
    .i_mode        (i_mode),
    .i_dc          (i_dc),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .display_csb   (display_csb),
    .spi_clk       (spi_clk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .data_commandb (data_commandb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic [1:0]  mode;
    logic        dc;
    int          miso;
    int          n;
    int          busy;
    logic [23:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  int n_checks;
  int n_fail;

  int          m_busy;
  int          m_csb_low;
  int          m_pulses;
  int          m_dcb_bad;
  int          m_rxv_busy;
  logic [23:0] m_mosi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at the first sample after an accept edge; returns at the first ready sample.
  task automatic monitor(input logic exp_dc);
    logic prev_sck;
    bit   done;
    prev_sck   = 1'b0;
    done       = 1'b0;
    m_busy     = 0;
    m_csb_low  = 0;
    m_pulses   = 0;
    m_dcb_bad  = 0;
    m_rxv_busy = 0;
    m_mosi     = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (o_ready) begin
        done = 1'b1;
      end else begin
        m_busy++;
        if (!display_csb) m_csb_low++;
        if (data_commandb !== exp_dc) m_dcb_bad++;
        if (o_rx_valid) m_rxv_busy++;
        if (spi_clk && !prev_sck) begin
          m_pulses++;
          m_mosi = {m_mosi[22:0], spi_mosi};
        end
        prev_sck = spi_clk;
        @(posedge clk);
        #1;
      end
    end
    chk("monitor_timeout", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [23:0] low_bits(input logic [23:0] d, input int n);
    logic [23:0] mask;
    mask = (n >= 24) ? 24'hFFFFFF : ((24'd1 << n) - 24'd1);
    return d & mask;
  endfunction

  task automatic run_txn(input int i);
    vec_t v;
    v = vecs[i];
    miso_sel = v.miso;
    chk($sformatf("v%0d_ready_before", i), {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1;
    i_data  = v.data;
    i_mode  = v.mode;
    i_dc    = v.dc;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_data  = ~v.data;
    i_dc    = ~v.dc;
    i_mode  = ~v.mode;
    monitor(v.dc);
    chk($sformatf("v%0d_busy", i), m_busy, v.busy);
    chk($sformatf("v%0d_csb_low", i), m_csb_low, v.busy);
    chk($sformatf("v%0d_pulses", i), m_pulses, v.n);
    chk($sformatf("v%0d_mosi", i), {8'd0, m_mosi}, {8'd0, low_bits(v.data, v.n)});
    chk($sformatf("v%0d_dcb_bad", i), m_dcb_bad, 0);
    chk($sformatf("v%0d_rxv_early", i), m_rxv_busy, 0);
    chk($sformatf("v%0d_rx_valid", i), {31'd0, o_rx_valid}, 32'd1);
    chk($sformatf("v%0d_rx_data", i), {8'd0, o_rx_data}, {8'd0, v.exp_rx});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_rxv_once", i), {31'd0, o_rx_valid}, 32'd0);
  endtask

  initial begin
    int rises;
    int rxv_seen;
    logic prev_sck;

    n_checks = 0;
    n_fail   = 0;
    miso_sel = 2;
    rst      = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    i_mode   = '0;
    i_dc     = 1'b0;

    vecs[0] = '{24'h00002A, 2'd0, 1'b0, 2,  8,  36, 24'h000000};
    vecs[1] = '{24'h00ABCD, 2'd1, 1'b1, 0, 16,  68, 24'h00ABCD};
    vecs[2] = '{24'h123456, 2'd2, 1'b1, 1, 24, 100, 24'hFFFFFF};
    vecs[3] = '{24'h123456, 2'd3, 1'b0, 1,  8,  36, 24'h0000FF};
    vecs[4] = '{24'hA5C3F0, 2'd2, 1'b0, 0, 24, 100, 24'hA5C3F0};
    vecs[5] = '{24'hFFFF00, 2'd0, 1'b1, 1,  8,  36, 24'h0000FF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_csb", {31'd0, display_csb}, 32'd1);
    chk("rst_sck", {31'd0, spi_clk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_dcb", {31'd0, data_commandb}, 32'd1);
    chk("rst_rx_data", {8'd0, o_rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_txn(i);

    // Back-to-back: second request waits on the bus and is picked up on the rx_valid cycle.
    miso_sel = 0;
    i_valid  = 1'b1;
    i_data   = 24'h000011;
    i_mode   = 2'd0;
    i_dc     = 1'b0;
    @(posedge clk);
    #1;
    i_data = 24'h000022;
    i_dc   = 1'b1;
    monitor(1'b0);
    chk("b2b_first_mosi", {8'd0, m_mosi}, 32'h11);
    chk("b2b_first_dcb_bad", m_dcb_bad, 0);
    chk("b2b_first_rx", {8'd0, o_rx_data}, 32'h11);
    chk("b2b_first_rxv", {31'd0, o_rx_valid}, 32'd1);
    chk("b2b_gap_csb", {31'd0, display_csb}, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    chk("b2b_second_ready", {31'd0, o_ready}, 32'd0);
    chk("b2b_second_csb", {31'd0, display_csb}, 32'd0);
    chk("b2b_second_dcb", {31'd0, data_commandb}, 32'd1);
    monitor(1'b1);
    chk("b2b_second_busy", m_busy, 36);
    chk("b2b_second_mosi", {8'd0, m_mosi}, 32'h22);
    chk("b2b_second_rx", {8'd0, o_rx_data}, 32'h22);
    @(posedge clk);
    #1;

    // Asynchronous reset partway through an 8-bit transfer.
    miso_sel = 1;
    i_valid  = 1'b1;
    i_data   = 24'h0000C3;
    i_mode   = 2'd0;
    i_dc     = 1'b0;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    rises    = 0;
    prev_sck = 1'b0;
    for (int c = 0; c < 100 && rises < 4; c++) begin
      @(posedge clk);
      #1;
      if (spi_clk && !prev_sck) rises++;
      prev_sck = spi_clk;
    end
    chk("rstmid_reached_bit3", rises, 4);
    #1;
    rst = 1'b0;
    #1;
    chk("rstmid_csb", {31'd0, display_csb}, 32'd1);
    chk("rstmid_sck", {31'd0, spi_clk}, 32'd0);
    chk("rstmid_ready", {31'd0, o_ready}, 32'd1);
    chk("rstmid_dcb", {31'd0, data_commandb}, 32'd1);
    rxv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (o_rx_valid) rxv_seen++;
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (o_rx_valid) rxv_seen++;
    end
    chk("rstmid_no_rxv", rxv_seen, 0);
    run_txn(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
